// File: rtl/clock_gen_prog_if.sv
// Control and status bundle for the programmable divided-clock generator.
// master drives enable/load/config, slave returns the clock and status.
interface clock_gen_prog_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] cfg_period;
    logic [WIDTH-1:0] cfg_high;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;
    logic             running;
    logic             cfg_err;
    logic [WIDTH-1:0] period_count;

    modport master (
        output enable, load, cfg_period, cfg_high,
        input  clk_out, rise_tick, fall_tick, running, cfg_err, period_count
    );

    modport slave (
        input  enable, load, cfg_period, cfg_high,
        output clk_out, rise_tick, fall_tick, running, cfg_err, period_count
    );
endinterface

// File: rtl/clock_gen_prog.sv
// Programmable divided clock: run-time period/high time, boundary-aligned
// reconfiguration, clean stop at a period end, and edge strobes.
module clock_gen_prog #(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 100,
    parameter int DEFAULT_HIGH   = 50
) (
    input logic             clk,
    input logic             rst,
    clock_gen_prog_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_HIGH);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] active_high;
    logic [WIDTH-1:0] pend_period;
    logic [WIDTH-1:0] pend_high;
    logic             pend;
    logic [WIDTH-1:0] pcount;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             run_q;
    logic             err_q;

    logic             cfg_ok;
    logic             last;
    logic             go_idle;
    logic             out_nxt;
    logic [WIDTH-1:0] cnt_nxt;

    always_comb begin
        cfg_ok  = (bus.cfg_period >= WIDTH'(2)) &&
                  (bus.cfg_high != '0) &&
                  (bus.cfg_high < bus.cfg_period);
        last    = (cnt == active_period - WIDTH'(1));
        cnt_nxt = last ? '0 : cnt + WIDTH'(1);
        go_idle = (state == STOP) && !bus.enable && last;
        // A stopping generator parks low instead of starting a new high phase
        out_nxt = !go_idle && (cnt_nxt < active_high);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            active_period <= DEF_P;
            active_high   <= DEF_H;
            pend_period   <= '0;
            pend_high     <= '0;
            pend          <= 1'b0;
            pcount        <= '0;
            clk_q         <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            run_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            err_q  <= bus.load && !cfg_ok;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load && cfg_ok) begin
                        active_period <= bus.cfg_period;
                        active_high   <= bus.cfg_high;
                    end
                    if (bus.enable) begin
                        state  <= RUN;
                        cnt    <= '0;
                        clk_q  <= 1'b1;
                        rise_q <= 1'b1;
                        run_q  <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    cnt    <= cnt_nxt;
                    clk_q  <= out_nxt;
                    rise_q <= out_nxt & ~clk_q;
                    fall_q <= ~out_nxt & clk_q;
                    if (last) begin
                        pcount <= pcount + WIDTH'(1);
                        if (pend) begin
                            active_period <= pend_period;
                            active_high   <= pend_high;
                            pend          <= 1'b0;
                        end
                    end
                    // Same-cycle load lands after the apply, so it waits a period
                    if (bus.load && cfg_ok) begin
                        pend_period <= bus.cfg_period;
                        pend_high   <= bus.cfg_high;
                        pend        <= 1'b1;
                    end
                    if (state == RUN) begin
                        if (!bus.enable)
                            state <= STOP;
                    end else if (bus.enable) begin
                        state <= RUN;
                    end else if (last) begin
                        state <= IDLE;
                        run_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.clk_out      = clk_q;
    assign bus.rise_tick    = rise_q;
    assign bus.fall_tick    = fall_q;
    assign bus.running      = run_q;
    assign bus.cfg_err      = err_q;
    assign bus.period_count = pcount;
endmodule

// File: tb/tb_clock_gen_prog.sv
// Randomised and directed bench for clock_gen_prog against a
// cycle-position reference model of the divided clock.
module tb_clock_gen_prog;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    clock_gen_prog_if #(.WIDTH(W)) bus ();

    clock_gen_prog #(
        .WIDTH(W),
        .DEFAULT_PERIOD(100),
        .DEFAULT_HIGH(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference: generator is "alive" with a position inside the period
    bit         m_alive;
    bit         m_prev_en;
    int         m_pos;
    int         m_ap, m_ah, m_pp, m_ph;
    bit         m_pend;
    logic [7:0] m_pc;
    bit         e_clk, e_prev, e_rise, e_fall, e_err;

    always @(posedge clk) begin
        bit v;
        bit last;
        v = bus.load && bus.cfg_period >= 2 && bus.cfg_high >= 1 &&
            bus.cfg_high < bus.cfg_period;
        if (rst) begin
            m_alive = 0; m_prev_en = 0; m_pos = 0;
            m_ap = 100; m_ah = 50; m_pend = 0; m_pp = 0; m_ph = 0;
            m_pc = '0; e_err = 0;
            e_clk = 0; e_rise = 0; e_fall = 0;
        end else begin
            e_err = bus.load && !v;
            if (!m_alive) begin
                if (v) begin m_ap = bus.cfg_period; m_ah = bus.cfg_high; end
                if (bus.enable) begin m_alive = 1; m_pos = 0; end
            end else begin
                last = (m_pos == m_ap - 1);
                if (last) begin
                    m_pc = m_pc + 8'd1;
                    if (m_pend) begin m_ap = m_pp; m_ah = m_ph; m_pend = 0; end
                end
                if (v) begin m_pp = bus.cfg_period; m_ph = bus.cfg_high; m_pend = 1; end
                m_pos = last ? 0 : m_pos + 1;
                if (last && !m_prev_en && !bus.enable) m_alive = 0;
            end
            m_prev_en = bus.enable;
            e_prev = e_clk;
            e_clk  = m_alive && (m_pos < m_ah);
            e_rise = e_clk && !e_prev;
            e_fall = !e_clk && e_prev;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("clk_out",      32'(bus.clk_out),      32'(e_clk));
        chk("rise_tick",    32'(bus.rise_tick),    32'(e_rise));
        chk("fall_tick",    32'(bus.fall_tick),    32'(e_fall));
        chk("running",      32'(bus.running),      32'(m_alive));
        chk("cfg_err",      32'(bus.cfg_err),      32'(e_err));
        chk("period_count", 32'(bus.period_count), 32'(m_pc));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_cfg(int p, int h);
        bus.cfg_period = W'(p);
        bus.cfg_high   = W'(h);
        bus.load       = 1'b1;
        tick();
        bus.load       = 1'b0;
    endtask

    task automatic wait_pos(int p);
        int i;
        i = 0;
        while (!(m_alive && m_pos == p) && i < 400) begin
            tick();
            i++;
        end
        if (!(m_alive && m_pos == p)) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pos: position %0d not reached at %0t", p, $time);
        end
    endtask

    task automatic count_highs(int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            h += int'(bus.clk_out);
            tick();
        end
    endtask

    initial begin
        int h, r, f, n;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_high = '0;
        tick();
        tick();
        chk("reset_clk_out", 32'(bus.clk_out), 0);
        chk("reset_count", 32'(bus.period_count), 0);
        chk("reset_running", 32'(bus.running), 0);

        // Defaults 100/50
        rst = 1'b0;
        bus.enable = 1'b1;
        tick();
        chk("first_rise", 32'(bus.clk_out), 1);
        chk("first_rise_tick", 32'(bus.rise_tick), 1);
        h = 0; r = 0; f = 0;
        for (int i = 0; i < 300; i++) begin
            h += int'(bus.clk_out);
            r += int'(bus.rise_tick);
            f += int'(bus.fall_tick);
            tick();
        end
        chk("default_highs", 32'(h), 150);
        chk("default_rises", 32'(r), 3);
        chk("default_falls", 32'(f), 3);
        chk("default_periods", 32'(bus.period_count), 3);

        // 10/3 loaded while idle
        bus.enable = 1'b0;
        n = 0;
        while (bus.running && n < 300) begin tick(); n++; end
        chk("idle_reached", 32'(bus.running), 0);
        load_cfg(10, 3);
        bus.enable = 1'b1;
        tick();
        count_highs(10, h);
        chk("p10_highs", 32'(h), 3);
        chk("p10_running", 32'(bus.running), 1);

        // Deferred reconfiguration mid-period and on the boundary
        wait_pos(5);
        load_cfg(4, 2);
        wait_pos(0);
        count_highs(4, h);
        chk("p4_highs", 32'(h), 2);
        load_cfg(10, 3);
        wait_pos(0);
        wait_pos(9);
        load_cfg(4, 2);
        count_highs(10, h);
        chk("boundary_load_deferred", 32'(h), 3);
        count_highs(4, h);
        chk("boundary_load_applied", 32'(h), 2);

        // Rejected configurations
        for (int k = 0; k < 3; k++) begin
            bus.cfg_period = (k == 0) ? W'(1) : W'(8);
            bus.cfg_high   = (k == 0) ? W'(1) : (k == 1) ? W'(0) : W'(8);
            bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            chk("cfg_err_pulse", 32'(bus.cfg_err), 1);
            tick();
            chk("cfg_err_clear", 32'(bus.cfg_err), 0);
        end
        wait_pos(0);
        count_highs(4, h);
        chk("p4_after_bad_loads", 32'(h), 2);

        // Clean stop from cnt = 1
        load_cfg(10, 3);
        wait_pos(0);
        wait_pos(1);
        bus.enable = 1'b0;
        tick();
        chk("stop_cnt2_high", 32'(bus.clk_out), 1);
        tick();
        chk("stop_cnt3_low", 32'(bus.clk_out), 0);
        n = 2;
        while (bus.running && n < 100) begin tick(); n++; end
        chk("stop_cycles", 32'(n), 9);

        // Re-raise enable before the boundary
        bus.enable = 1'b1;
        tick();
        wait_pos(1);
        bus.enable = 1'b0;
        wait_pos(6);
        bus.enable = 1'b1;
        repeat (25) tick();
        chk("resume_running", 32'(bus.running), 1);
        wait_pos(0);
        count_highs(10, h);
        chk("resume_highs", 32'(h), 3);

        // Reset mid-period discards pending config
        wait_pos(0);
        load_cfg(4, 2);
        chk("pre_reset_high", 32'(bus.clk_out), 1);
        rst = 1'b1;
        tick();
        chk("rst_clk_out", 32'(bus.clk_out), 0);
        chk("rst_count", 32'(bus.period_count), 0);
        rst = 1'b0;
        tick();
        count_highs(100, h);
        chk("rst_defaults", 32'(h), 50);

        // Shortest period, long enough to wrap period_count
        load_cfg(2, 1);
        repeat (700) tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
            rst = ($urandom_range(0, 399) == 0);
            bus.load = ($urandom_range(0, 14) == 0);
            bus.cfg_period = W'($urandom_range(0, 12));
            bus.cfg_high   = W'($urandom_range(0, 12));
            tick();
        end
        rst = 1'b0;
        bus.load = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
